multicycle_control: RTL

Multi-cycle successor to the single-cycle MIPS control decoder. A registered FSM sequences fetch, decode, execute, memory and write-back over several cycles. Every memory access waits on a `mem_ready` handshake, guarded by a parametrised timeout. The block drives the shared-ALU/shared-memory multicycle datapath. It supports R-type, `jr`, `beq`, `bne`, `lw`, `sw`, `addi`, `andi`, `lui` and `j`.

---
 rtl/control_pkg.sv | 48 ++++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// funct codes and datapath mux selects.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12,
    S_ERROR  = 4'd15
  } state_t;

  localparam logic [5:0] R_TYPE  = 6'b000000;
  localparam logic [5:0] LW      = 6'b100011;
  localparam logic [5:0] SW      = 6'b101011;
  localparam logic [5:0] BEQ     = 6'b000100;
  localparam logic [5:0] BNE     = 6'b000101;
  localparam logic [5:0] ADDI    = 6'b001000;
  localparam logic [5:0] ANDI    = 6'b001100;
  localparam logic [5:0] LUI     = 6'b001111;
  localparam logic [5:0] J       = 6'b000010;
  localparam logic [5:0] FUNC_JR = 6'b001000;

  localparam logic [2:0] ALU_FUNC = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b100;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access and flags the
// cycle in which the count reaches MEM_TIMEOUT (0 disables the flag).
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic wait_en,
  output logic expired
);

  localparam int unsigned W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned LIM = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (clear)
      r_count <= '0;
    else if (wait_en)
      r_count <= r_count + 1'b1;
  end

  // Fires on the stall cycle whose increment lands on MEM_TIMEOUT, so the
  // FSM leaves for ERROR on that same edge.
  assign expired = (MEM_TIMEOUT != 0) && wait_en && !clear && (r_count == W'(LIM));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: registered state, combinational decode of the
// datapath controls, mem_ready handshake with timeout into a sticky ERROR.
module multicycle_control
  import control_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         instruction,
  input  logic [5:0]         func,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               PCWriteCondNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               LUI,
  output logic [3:0]         state_out,
  output logic               err,
  output logic               illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic       w_in_mem;
  logic       w_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_op <= instruction;
    end
  end

  assign w_in_mem = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!w_in_mem || mem_ready),
    .wait_en (w_in_mem && !mem_ready),
    .expired (w_expired)
  );

  always_comb begin
    w_next        = r_state;
    ALUOp         = '0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_RT;
    PCSrc         = PC_ALU;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    LUI           = 1'b0;
    illegal       = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALUOP_W'(ALU_ADD);
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = S_DECODE;
        end else if (w_expired) begin
          w_next = S_ERROR;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_SHIFT;
        ALUOp   = ALUOP_W'(ALU_ADD);
        case (instruction)
          LW, SW:                      w_next = S_MEMADR;
          R_TYPE:                      w_next = (func == FUNC_JR) ? S_JR : S_EXEC;
          BEQ, BNE:                    w_next = S_BRANCH;
          ADDI, ANDI, control_pkg::LUI: w_next = S_IMMEX;
          J:                           w_next = S_JUMP;
          default: begin
            w_next  = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_W'(ALU_ADD);
        w_next  = (instruction == SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_expired) w_next = S_ERROR;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_expired) w_next = S_ERROR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_W'(ALU_FUNC);
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALUOP_W'(ALU_SUB);
        PCSrc         = PC_ALUOUT;
        PCWriteCond   = (r_op == BEQ);
        PCWriteCondNE = (r_op == BNE);
        w_next        = S_FETCH;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = (r_op == ANDI) ? ALUOP_W'(ALU_AND) : ALUOP_W'(ALU_ADD);
        LUI     = (r_op == control_pkg::LUI);
        w_next  = S_IMMWB;
      end
      S_IMMWB: begin
        RegWrite = 1'b1;
        LUI      = (r_op == control_pkg::LUI);
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = PC_JUMP;
        w_next  = S_FETCH;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = PC_RS;
        w_next  = S_FETCH;
      end
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_FETCH;
    endcase
  end

  assign state_out = r_state;
  assign err       = (r_state == S_ERROR);

endmodule
